rackbus_align_ctrl: RTL

RACKBUS_ALIGN_CTRL -- requirements
Module: rackbus_align_ctrl

---
 rtl/rackbus_align_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rackbus_align_ctrl.sv
// rackbus_align_ctrl: ISERDES word-alignment trainer for the rack backplane link.
// On request it pulses the SERDES reset, lets the link settle, then hunts for
// PATTERN by issuing bitslips until MATCH_COUNT consecutive words match (lock)
// or MAX_SLIP slips have been exhausted (fail).
// Optional build macro RACKBUS_ALIGN_ERRCNT_EN adds a saturating counter of bad
// words observed while locked; without it err_count_o is tied to zero.
module rackbus_align_ctrl #(
  parameter logic [5:0] PATTERN       = 6'b011001,
  parameter int         RESET_CYCLES  = 8,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         SLIP_WAIT     = 4,
  parameter int         MATCH_COUNT   = 64,
  parameter int         MAX_SLIP      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [5:0]  dat_i,
  input  logic        check_i,
  output logic        io_reset_o,
  output logic        bitslip_o,
  output logic        busy_o,
  output logic        locked_o,
  output logic        fail_o,
  output logic [2:0]  slip_count_o,
  output logic [15:0] err_count_o
);

  localparam int TMAX12 = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int TMAX   = (TMAX12 > SLIP_WAIT) ? TMAX12 : SLIP_WAIT;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int MW     = $clog2(MATCH_COUNT + 1);

  localparam logic [TW-1:0] RST_LOAD    = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LOAD   = TW'(SLIP_WAIT - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [2:0]    SLIP_LIMIT  = 3'(MAX_SLIP);

  typedef enum logic [2:0] {
    IDLE, IORST, SETTLE, CHECK, SLIP, SLIPWAIT, LOCKED, FAIL
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [TW-1:0]   timer;
  logic [MW-1:0]   match_count;
  logic [2:0]      slip_count;
  logic            io_reset_q;
  logic            word_match;
  logic            start_accept;

  assign word_match   = (dat_i == PATTERN);
  assign start_accept = start_i && ((state == IDLE) || (state == LOCKED) || (state == FAIL));

  // State register; reset always returns to IDLE regardless of start_i.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decision: timed phases run off the shared timer, CHECK decides slip/lock/fail.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, LOCKED, FAIL: if (start_i) next_state = IORST;
      IORST:              if (timer == '0) next_state = SETTLE;
      SETTLE:             if (timer == '0) next_state = CHECK;
      CHECK: begin
        if (!word_match)                next_state = (slip_count == SLIP_LIMIT) ? FAIL : SLIP;
        else if (match_count == MATCH_LAST) next_state = LOCKED;
      end
      SLIP:               next_state = SLIPWAIT;
      SLIPWAIT:           if (timer == '0) next_state = CHECK;
      default:            next_state = IDLE;
    endcase
  end

  // Shared down-counter reloads whenever a timed state is entered, then counts to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (next_state != state) begin
      case (next_state)
        IORST:    timer <= RST_LOAD;
        SETTLE:   timer <= SETTLE_LOAD;
        SLIPWAIT: timer <= WAIT_LOAD;
        default:  timer <= '0;
      endcase
    end else if (timer != '0) begin
      timer <= timer - TW'(1);
    end
  end

  // Consecutive-match counter: any mismatch or a new slip attempt starts the run over.
  always_ff @(posedge clk) begin
    if (rst || start_accept || (state == SLIPWAIT)) begin
      match_count <= '0;
    end else if (state == CHECK) begin
      if (word_match) match_count <= match_count + MW'(1);
      else            match_count <= '0;
    end
  end

  // Slip counter advances on the CHECK->SLIP decision and holds in LOCKED/FAIL.
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      slip_count <= '0;
    end else if ((state == CHECK) && (next_state == SLIP) && (slip_count < SLIP_LIMIT)) begin
      slip_count <= slip_count + 3'd1;
    end
  end

  // SERDES reset is a flop so it leaves the block glitch-free.
  always_ff @(posedge clk) begin
    if (rst) io_reset_q <= 1'b0;
    else     io_reset_q <= (next_state == IORST);
  end

`ifdef RACKBUS_ALIGN_ERRCNT_EN
  logic [15:0] err_count;

  // Saturating count of bad words while locked and the far end claims to send PATTERN.
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      err_count <= '0;
    end else if ((state == LOCKED) && check_i && !word_match && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

  assign err_count_o = err_count;
`else
  logic unused_check;
  assign unused_check = check_i;
  assign err_count_o  = '0;
`endif

  assign io_reset_o   = io_reset_q;
  assign bitslip_o    = (state == SLIP);
  assign busy_o       = !((state == IDLE) || (state == LOCKED) || (state == FAIL));
  assign locked_o     = (state == LOCKED);
  assign fail_o       = (state == FAIL);
  assign slip_count_o = slip_count;

endmodule
